// File: rtl/theia_tmem_pkg.sv
// Shared TMEM crossbar definitions.
// Holds the bank scheduler state encoding and width helpers.
package theia_tmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2
    } tmem_state_e;

    // Index width for n items, never below one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin winner search.
// Search starts one past ptr and wraps upward.
module rr_priority_pick #(
    parameter int NUM_REQ = 16,
    parameter int SEL_W   = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [SEL_W-1:0]   idx,
    output logic               valid
);

    // First requester found after ptr wins.
    always_comb begin
        logic [SEL_W-1:0] k;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        k      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = SEL_W'((int'(ptr) + i) % NUM_REQ);
            if (!valid && req[k]) begin
                valid     = 1'b1;
                idx       = k;
                onehot[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tmem_bank_scheduler.sv
// Per-bank TMEM read scheduler.
// Round-robin grant, one read per three cycles, host hold.
module tmem_bank_scheduler
    import theia_tmem_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = clog2(NUM_REQ)
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic [NUM_REQ-1:0]        REQ_I,
    input  logic [NUM_REQ*ADDR_W-1:0] ADR_I,
    input  logic                      HOLD_I,
    input  logic [DATA_W-1:0]         RAM_DAT_I,
    output logic                      RAM_RD_O,
    output logic [ADDR_W-1:0]         RAM_ADR_O,
    output logic [NUM_REQ-1:0]        GNT_O,
    output logic [SEL_W-1:0]          SEL_O,
    output logic [NUM_REQ-1:0]        ACK_O,
    output logic [DATA_W-1:0]         DAT_O,
    output logic                      BUSY_O
);

    tmem_state_e        state;
    logic [SEL_W-1:0]   ptr;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] win_oh;
    logic [SEL_W-1:0]   win_idx;
    logic               win_valid;
    logic [ADDR_W-1:0]  adr_arr [NUM_REQ];

    // The core being acked still holds its request; hide it.
    assign eligible = REQ_I & ~ACK_O;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req    (eligible),
        .ptr    (ptr),
        .onehot (win_oh),
        .idx    (win_idx),
        .valid  (win_valid)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_adr
        assign adr_arr[g] = ADR_I[g*ADDR_W +: ADDR_W];
    end

    assign BUSY_O    = (state != IDLE);
    assign RAM_RD_O  = (state == RD);
    assign RAM_ADR_O = RAM_RD_O ? adr_arr[SEL_O] : '0;

    // Grant FSM with registered grant, ack and read data.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state <= IDLE;
            GNT_O <= '0;
            ACK_O <= '0;
            DAT_O <= '0;
            SEL_O <= '0;
            ptr   <= SEL_W'(NUM_REQ - 1);
        end else begin
            ACK_O <= '0;
            unique case (state)
                IDLE: begin
                    if (!HOLD_I && win_valid) begin
                        SEL_O <= win_idx;
                        GNT_O <= win_oh;
                        ptr   <= win_idx;
                        state <= RD;
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    DAT_O <= RAM_DAT_I;
                    ACK_O <= GNT_O;
                    GNT_O <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
